// File: rtl/bus_mem_slave_ws.sv
`default_nettype none
// ============================================================================
// Module   : bus_mem_slave_ws
// Purpose  : Word-organised RAM slave for the single-core system bus.
//            - Decodes its own address window and ignores addresses outside it.
//            - Supports byte-enabled single and burst reads/writes.
//            - Inserts programmable read wait states, reported on bus_busy_o.
//            - Returns an error for bursts that run past the end of the window.
//            - Honours a master-side abort on bus_endTransaction_i.
// Ports    :
//   clk_i                  clock, rising edge
//   rst_n_i                asynchronous active-low reset
//   bus_addrData_i   [31:0] address on the begin cycle, write data otherwise
//   bus_byteEnables_i [3:0] byte lane enables (begin cycle)
//   bus_burstSize_i   [7:0] beats minus one (begin cycle)
//   bus_readNWrite_i        1 = read, 0 = write (begin cycle)
//   bus_beginTransaction_i  start of a transaction
//   bus_endTransaction_i    master end / abort
//   bus_dataValid_i         write beat valid
//   bus_addrData_o   [31:0] read data, 0 outside read beats
//   bus_endTransaction_o    last read beat or error termination
//   bus_dataValid_o         read beat valid
//   bus_busy_o              read wait states in progress
//   bus_error_o             range error
// Revision : 1.0 - initial release
// ============================================================================
module bus_mem_slave_ws #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned READ_WAIT = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] bus_addrData_i,
  input  logic [3:0]  bus_byteEnables_i,
  input  logic [7:0]  bus_burstSize_i,
  input  logic        bus_readNWrite_i,
  input  logic        bus_beginTransaction_i,
  input  logic        bus_endTransaction_i,
  input  logic        bus_dataValid_i,
  output logic [31:0] bus_addrData_o,
  output logic        bus_endTransaction_o,
  output logic        bus_dataValid_o,
  output logic        bus_busy_o,
  output logic        bus_error_o
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam bit          HAS_WAIT  = (READ_WAIT != 0);
  // The wait counter counts down to zero, so it starts one below the wait count.
  localparam logic [3:0]  WAIT_INIT = HAS_WAIT ? 4'(READ_WAIT - 1) : 4'd0;
  localparam logic [31:0] WORDS_32  = 32'(MEM_WORDS);
  localparam logic [32:0] WORDS_33  = 33'(MEM_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RWAIT = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [7:0]         rem_q,   rem_d;
  logic [3:0]         wait_q,  wait_d;
  logic [3:0]         be_q,    be_d;

  logic [31:0]        mem [MEM_WORDS];

  logic [29:0]        w_off_words;
  logic               w_hit;
  logic [32:0]        w_last_word;
  logic               w_range_err;
  logic [31:0]        w_mask;
  logic               w_wr_beat;

  // --------------------------------------------------------------------------
  // Address decode. BASE_ADDR is word aligned, so subtracting the word parts
  // gives the same word offset as (addr - BASE_ADDR) >> 2 while ignoring the
  // low two address bits.
  // --------------------------------------------------------------------------
  assign w_off_words = bus_addrData_i[31:2] - BASE_ADDR[31:2];
  assign w_hit       = (bus_addrData_i >= BASE_ADDR) &&
                       ({2'b00, w_off_words} < WORDS_32);
  // Wide enough that first word + burst length can never wrap.
  assign w_last_word = {3'b000, w_off_words} + {25'd0, bus_burstSize_i};
  assign w_range_err = (w_last_word >= WORDS_33);

  // Byte mask: each latched enable bit covers its byte lane.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_mask
    assign w_mask[gi*8 +: 8] = {8{be_q[gi]}};
  end

  assign w_wr_beat = (state_q == ST_WRITE) && bus_dataValid_i;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    wait_d  = wait_q;
    be_d    = be_q;

    case (state_q)
      ST_IDLE: begin
        if (bus_beginTransaction_i && w_hit) begin
          idx_d  = w_off_words[IDX_W-1:0];
          rem_d  = bus_burstSize_i;
          be_d   = bus_byteEnables_i;
          wait_d = WAIT_INIT;
          if (w_range_err) begin
            state_d = ST_ERR;
          end else if (bus_readNWrite_i) begin
            state_d = HAS_WAIT ? ST_RWAIT : ST_READ;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end

      ST_RWAIT: begin
        if (bus_endTransaction_i) begin
          state_d = ST_IDLE;
        end else if (wait_q == 4'd0) begin
          state_d = ST_READ;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      ST_READ: begin
        // The beat shown this cycle always counts; an abort only prevents
        // any further beats.
        idx_d = idx_q + 1'b1;
        rem_d = rem_q - 8'd1;
        if (bus_endTransaction_i || (rem_q == 8'd0)) begin
          state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        if (bus_dataValid_i) begin
          idx_d = idx_q + 1'b1;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd0) begin
            state_d = ST_IDLE;
          end
        end
        if (bus_endTransaction_i) begin
          state_d = ST_IDLE;
        end
      end

      ST_ERR: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      wait_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      be_q    <= be_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage. Not reset; a write only happens on a clock edge in WRITE, so an
  // asynchronous reset can never leave a partial beat behind.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_wr_beat) begin
      mem[idx_q] <= (mem[idx_q] & ~w_mask) | (bus_addrData_i & w_mask);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from registered state only.
  // --------------------------------------------------------------------------
  assign bus_dataValid_o      = (state_q == ST_READ);
  assign bus_addrData_o       = (state_q == ST_READ) ? (mem[idx_q] & w_mask) : 32'd0;
  assign bus_busy_o           = (state_q == ST_RWAIT);
  assign bus_error_o          = (state_q == ST_ERR);
  assign bus_endTransaction_o = (state_q == ST_ERR) ||
                                ((state_q == ST_READ) && (rem_q == 8'd0));

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_slave_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_mem_slave_ws
// Purpose  : Self-checking bench for bus_mem_slave_ws (16 words at 0x1000,
//            two read wait states). A word-array model predicts every output
//            cycle of each transaction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_mem_slave_ws;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WORDS = 16;
  localparam int          RW    = 2;

  localparam int K_MISS = 0;
  localparam int K_ERR  = 1;
  localparam int K_OK   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr_i = '0;
  logic [3:0]  be_i = '0;
  logic [7:0]  burst_i = '0;
  logic        rnw_i = 1'b0;
  logic        begin_i = 1'b0;
  logic        end_i = 1'b0;
  logic        dv_i = 1'b0;
  logic [31:0] data_o;
  logic        end_o;
  logic        dv_o;
  logic        busy_o;
  logic        err_o;

  always #5 clk = ~clk;

  bus_mem_slave_ws #(
    .BASE_ADDR(BASE),
    .MEM_WORDS(WORDS),
    .READ_WAIT(RW)
  ) dut (
    .clk_i                 (clk),
    .rst_n_i               (rst_n),
    .bus_addrData_i        (addr_i),
    .bus_byteEnables_i     (be_i),
    .bus_burstSize_i       (burst_i),
    .bus_readNWrite_i      (rnw_i),
    .bus_beginTransaction_i(begin_i),
    .bus_endTransaction_i  (end_i),
    .bus_dataValid_i       (dv_i),
    .bus_addrData_o        (data_o),
    .bus_endTransaction_o  (end_o),
    .bus_dataValid_o       (dv_o),
    .bus_busy_o            (busy_o),
    .bus_error_o           (err_o)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] model [WORDS];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [7:0]  burst;
    logic        rnw;
    int          abort;     // 0 none, k>0 abort with beat k, -1 abort in first wait cycle
    int          gap_after; // write: stall after this beat (0 = none)
    int          gap_len;
    logic        use_fixed; // write data = fixed + beat number
    logic [31:0] fixed;
    int          kind;      // expected response class
  } vec_t;

  // Packed view of outputs: {dv, end, busy, err, data}
  function automatic logic [35:0] pk(input logic dv, input logic en, input logic bz,
                                     input logic er, input logic [31:0] d);
    return {dv, en, bz, er, d};
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic int classify(input logic [31:0] addr, input logic [7:0] burst);
    logic [31:0] w;
    if (addr < BASE) return K_MISS;
    w = (addr - BASE) >> 2;
    if (w >= 32'(WORDS)) return K_MISS;
    if (int'(w) + int'(burst) >= WORDS) return K_ERR;
    return K_OK;
  endfunction

  task automatic chk(input string name, input logic [35:0] exp);
    logic [35:0] act;
    act = {dv_o, end_o, busy_o, err_o, data_o};
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got dv=%0b end=%0b busy=%0b err=%0b data=%08h, want dv=%0b end=%0b busy=%0b err=%0b data=%08h",
               name, act[35], act[34], act[33], act[32], act[31:0],
               exp[35], exp[34], exp[33], exp[32], exp[31:0]);
    end
  endtask

  // Called at a falling edge; drives one whole transaction and checks every
  // cycle. Returns at the falling edge of the first cycle after it.
  task automatic do_txn(input string tag, input vec_t v);
    int          w;
    int          nb;
    logic [31:0] m;
    logic [31:0] d;
    chk({tag, ":idle"}, '0);
    addr_i  = v.addr;
    be_i    = v.be;
    burst_i = v.burst;
    rnw_i   = v.rnw;
    begin_i = 1'b1;
    @(negedge clk);
    begin_i = 1'b0; addr_i = '0; be_i = '0; burst_i = '0; rnw_i = 1'b0;
    m  = bmask(v.be);
    w  = (v.kind == K_MISS) ? 0 : int'((v.addr - BASE) >> 2);
    nb = (v.abort > 0) ? v.abort : int'(v.burst) + 1;
    if (v.kind == K_MISS) begin
      for (int i = 0; i < 3; i++) begin
        chk({tag, ":miss"}, '0);
        if (!v.rnw) begin dv_i = 1'b1; addr_i = $urandom; end
        @(negedge clk);
      end
      dv_i = 1'b0; addr_i = '0;
    end else if (v.kind == K_ERR) begin
      for (int i = 0; i < 3; i++) begin
        chk({tag, ":err"}, (i == 0) ? pk(1'b0, 1'b1, 1'b0, 1'b1, 32'd0) : 36'd0);
        if (!v.rnw) begin dv_i = 1'b1; addr_i = $urandom; end
        @(negedge clk);
      end
      dv_i = 1'b0; addr_i = '0;
    end else if (v.rnw) begin
      if (v.abort < 0) begin
        chk({tag, ":busy"}, pk(1'b0, 1'b0, 1'b1, 1'b0, 32'd0));
        end_i = 1'b1;
        @(negedge clk);
        end_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
          chk({tag, ":after_wait_abort"}, '0);
          @(negedge clk);
        end
      end else begin
        for (int i = 0; i < RW; i++) begin
          chk({tag, ":busy"}, pk(1'b0, 1'b0, 1'b1, 1'b0, 32'd0));
          @(negedge clk);
        end
        for (int k = 0; k < nb; k++) begin
          chk($sformatf("%s:beat%0d", tag, k),
              pk(1'b1, k == int'(v.burst), 1'b0, 1'b0, model[w+k] & m));
          end_i = (k + 1 == v.abort);
          @(negedge clk);
        end
        end_i = 1'b0;
        chk({tag, ":post"}, '0);
      end
    end else begin
      for (int k = 0; k < nb; k++) begin
        chk({tag, ":wr"}, '0);
        d = v.use_fixed ? v.fixed + 32'(k) : $urandom;
        dv_i = 1'b1; addr_i = d; end_i = (k + 1 == v.abort);
        model[w+k] = (model[w+k] & ~m) | (d & m);
        @(negedge clk);
        if (k + 1 == v.gap_after) begin
          for (int g = 0; g < v.gap_len; g++) begin
            dv_i = 1'b0; end_i = 1'b0; addr_i = $urandom;
            chk({tag, ":stall"}, '0);
            @(negedge clk);
          end
        end
      end
      dv_i = 1'b0; end_i = 1'b0; addr_i = '0;
      chk({tag, ":post"}, '0);
    end
  endtask

  vec_t vecs[17];
  vec_t rv;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset", '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset", '0);

    // Fill the whole array so every later read has a known value.
    rv = '{BASE, 4'hF, 8'd15, 1'b0, 0, 0, 0, 1'b0, 32'd0, K_OK};
    do_txn("fill", rv);

    vecs[0]  = '{32'h100C, 4'hF,    8'd0, 1'b0,  0, 0, 0, 1'b1, 32'hA5A5_5A5A, K_OK};
    vecs[1]  = '{32'h100C, 4'b0101, 8'd0, 1'b1,  0, 0, 0, 1'b0, 32'd0,         K_OK};
    vecs[2]  = '{32'h1000, 4'hF,    8'd3, 1'b0,  0, 2, 2, 1'b1, 32'd1,         K_OK};
    vecs[3]  = '{32'h1000, 4'hF,    8'd3, 1'b1,  0, 0, 0, 1'b0, 32'd0,         K_OK};
    vecs[4]  = '{32'h1038, 4'hF,    8'd2, 1'b1,  0, 0, 0, 1'b0, 32'd0,         K_ERR};
    vecs[5]  = '{32'h1038, 4'hF,    8'd2, 1'b0,  0, 0, 0, 1'b0, 32'd0,         K_ERR};
    vecs[6]  = '{32'h1038, 4'hF,    8'd1, 1'b1,  0, 0, 0, 1'b0, 32'd0,         K_OK};
    vecs[7]  = '{32'h0FFC, 4'hF,    8'd0, 1'b1,  0, 0, 0, 1'b0, 32'd0,         K_MISS};
    vecs[8]  = '{32'h1040, 4'hF,    8'd1, 1'b0,  0, 0, 0, 1'b0, 32'd0,         K_MISS};
    vecs[9]  = '{32'h1000, 4'hF,    8'd7, 1'b1,  3, 0, 0, 1'b0, 32'd0,         K_OK};
    vecs[10] = '{32'h1004, 4'hF,    8'd0, 1'b1,  0, 0, 0, 1'b0, 32'd0,         K_OK};
    vecs[11] = '{32'h1010, 4'b0011, 8'd2, 1'b0,  2, 0, 0, 1'b0, 32'd0,         K_OK};
    vecs[12] = '{32'h1010, 4'hF,    8'd2, 1'b1,  0, 0, 0, 1'b0, 32'd0,         K_OK};
    vecs[13] = '{32'h1000, 4'hF,    8'd3, 1'b1, -1, 0, 0, 1'b0, 32'd0,         K_OK};
    vecs[14] = '{32'h1003, 4'b1100, 8'd0, 1'b1,  0, 0, 0, 1'b0, 32'd0,         K_OK};
    vecs[15] = '{32'h103C, 4'hF,    8'd0, 1'b1,  0, 0, 0, 1'b0, 32'd0,         K_OK};
    vecs[16] = '{32'h103C, 4'hF,    8'd1, 1'b1,  0, 0, 0, 1'b0, 32'd0,         K_ERR};

    for (int i = 0; i < 17; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i]);
      if (i == 1) begin
        // Word 3 = A5A5_5A5A read with BE 0101 must give 00A5_005A.
        n_total++;
        if ((model[3] & bmask(4'b0101)) !== 32'h00A5_005A) begin
          n_bad++;
          $display("FAIL masked_const: got %08h want 00a5005a", model[3] & bmask(4'b0101));
        end
      end
    end

    // Asynchronous reset while in read wait states.
    chk("rst_seq:idle", '0);
    addr_i = 32'h1000; be_i = 4'hF; burst_i = 8'd2; rnw_i = 1'b1; begin_i = 1'b1;
    @(negedge clk);
    begin_i = 1'b0; addr_i = '0; be_i = '0; burst_i = '0; rnw_i = 1'b0;
    chk("rst_seq:busy", pk(1'b0, 1'b0, 1'b1, 1'b0, 32'd0));
    #2 rst_n = 1'b0;
    #1 chk("rst_seq:async_clear", '0);
    @(negedge clk);
    chk("rst_seq:held", '0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_seq:no_beat", '0);
    end
    rv = '{32'h1008, 4'hF, 8'd1, 1'b1, 0, 0, 0, 1'b0, 32'd0, K_OK};
    do_txn("rst_seq:next", rv);

    // Randomized transactions around and across the window.
    for (int t = 0; t < 60; t++) begin
      rv.addr      = BASE - 32'd8 + 32'($urandom_range(0, 80));
      rv.be        = 4'($urandom_range(0, 15));
      rv.burst     = 8'($urandom_range(0, 5));
      rv.rnw       = 1'($urandom_range(0, 1));
      rv.abort     = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, int'(rv.burst) + 1)) : 0;
      rv.gap_after = int'($urandom_range(0, 3));
      rv.gap_len   = int'($urandom_range(0, 2));
      rv.use_fixed = 1'b0;
      rv.fixed     = '0;
      rv.kind      = classify(rv.addr, rv.burst);
      do_txn($sformatf("rnd%0d", t), rv);
    end

    // Full read-back of the array.
    rv = '{BASE, 4'hF, 8'd15, 1'b1, 0, 0, 0, 1'b0, 32'd0, K_OK};
    do_txn("readback", rv);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_mem_slave_ws.md
# bus_mem_slave_ws

Parametrised bus memory slave for the single-core system bus: a word-organised RAM that decodes its own address window and supports byte-enabled single and burst transfers. It adds three behaviours to the existing testbench memory model: programmable read wait states signalled on `bus_busy_o`, an error response for bursts that run past the window, and master-side abort. It sits on the shared bus beside other slaves, so it stays silent for addresses outside its window.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- `MEM_WORDS`, 1024: depth in 32-bit words; a power of two, range 2..65536.
- `READ_WAIT`, 2: wait cycles before the first read beat; range 0..15.

- `clk_i`  in  1: clock, rising edge.
- `rst_n_i`  in  1: asynchronous, active-low reset.
- `bus_addrData_i`  in  32: address on the begin cycle, write data otherwise.
- `bus_byteEnables_i`  in  4: byte lane enables, sampled on the begin cycle.
- `bus_burstSize_i`  in  8: beats minus one, sampled on the begin cycle.
- `bus_readNWrite_i`  in  1: 1 = read, 0 = write; sampled on the begin cycle.
- `bus_beginTransaction_i`  in  1: start of a transaction.
- `bus_endTransaction_i`  in  1: master end or abort.
- `bus_dataValid_i`  in  1: write beat valid.
- `bus_addrData_o`  out  32: read data; 0 when not in a read beat.
- `bus_endTransaction_o`  out  1: last read beat, or error termination.
- `bus_dataValid_o`  out  1: read beat valid.
- `bus_busy_o`  out  1: read wait states in progress.
- `bus_error_o`  out  1: range error.

## Operation
- State register: IDLE, RWAIT, READ, WRITE, ERR.
- Registers:
  - word index `idx_r` (log2(MEM_WORDS) bits);
  - remaining beats `rem_r` (8 bits, loaded with burstSize);
  - wait counter (4 bits);
  - latched byte enables.
- Byte mask = each enable bit replicated over its byte.
- Address decode, on `bus_beginTransaction_i` in IDLE:
  - `off = bus_addrData_i - BASE_ADDR` (32-bit, wrapping).
  - Hit iff `bus_addrData_i >= BASE_ADDR` and `off>>2 < MEM_WORDS`; bits [1:0] are ignored.
  - Miss: remain IDLE with all outputs 0.
- Range check on a hit: if `(off>>2) + burstSize >= MEM_WORDS` (computed ≥17 bits wide), go to ERR. No memory access occurs.
- Hit and in range:
  - Read: go to RWAIT if READ_WAIT>0, else READ.
  - Write: go to WRITE.
- RWAIT: `bus_busy_o`=1; counts READ_WAIT cycles, then goes to READ.
- READ, one beat per cycle:
  - `bus_dataValid_o`=1, `bus_addrData_o` = mem[idx_r] & mask.
  - `idx_r`++, `rem_r`--.
  - When `rem_r`==0: `bus_endTransaction_o`=1, next state IDLE.
- WRITE:
  - Each cycle with `bus_dataValid_i`=1: mem[idx_r] = (old & ~mask) | (data & mask), then `idx_r`++, `rem_r`--.
  - Cycles without `bus_dataValid_i` are stall cycles: no change.
  - After the beat with `rem_r`==0, go to IDLE.
  - The slave never drives `bus_endTransaction_o` for writes.
- ERR: `bus_error_o`=1 and `bus_endTransaction_o`=1 for exactly one cycle, then IDLE.
- Abort: `bus_endTransaction_i`=1 in RWAIT, READ or WRITE returns to IDLE next cycle.
  - A write beat presented in the same cycle is still written.
  - A read beat already presented in that cycle is the last one.
- `bus_beginTransaction_i` outside IDLE is ignored.
- Memory is not affected by reset. Simulation initial contents are 0.

## Timing
- Reset (asynchronous, while `rst_n_i`=0):
  - state IDLE; all outputs 0; `idx_r`, `rem_r` and the wait counter cleared.
  - Mid-transaction reset abandons the transaction. Writes already performed remain; no partial beat is written.
- Begin sampled at edge E (end of cycle T).
- Reads:
  - First beat in cycle T+1+READ_WAIT.
  - Last beat in cycle T+1+READ_WAIT+burstSize.
  - `bus_busy_o` high in cycles T+1 .. T+READ_WAIT.
- Writes: first beat accepted in cycle T+1 at the earliest.
- Error: `bus_error_o`/`bus_endTransaction_o` high in cycle T+1 only.
- Back-to-back: a new begin is accepted in the first IDLE cycle after the previous end, with no dead cycle beyond it.
- Outputs are registered-state decoded. Read data is combinational from the array at `idx_r`.

## Test plan
- Read timing and byte masking:
  - Stimulus: BASE=0x1000, READ_WAIT=2; write 0xA5A5_5A5A to word 3; read 0x100C, burst 0, BE=4'b0101.
  - Required: busy in T+1..T+2; in T+3 `bus_dataValid_o`=1, `bus_addrData_o`=0x00A5_005A, `bus_endTransaction_o`=1.
- Burst write with stalls, then read-back:
  - Stimulus: write burst 3 at 0x1000 with data 1,2,3,4 and a 2-cycle `bus_dataValid_i` gap after beat 2; then read burst 3, BE=4'hF.
  - Required: read beats return 1,2,3,4 on consecutive cycles; `bus_endTransaction_o` on the 4th beat only.
- Range error:
  - Stimulus: MEM_WORDS=16; read at word 14, burst 2.
  - Required: `bus_error_o`=`bus_endTransaction_o`=1 for one cycle; no `bus_dataValid_o`. Words 14..15 are unchanged after an equivalent write attempt.
- Address miss:
  - Stimulus: begin at BASE-4, then at BASE+4*MEM_WORDS.
  - Required: all outputs stay 0, memory unchanged.
- Abort:
  - Stimulus: read burst 7; `bus_endTransaction_i` asserted during the 3rd beat.
  - Required: exactly 3 valid beats, IDLE next cycle. A following single read completes normally.
- Asynchronous reset mid-RWAIT:
  - Stimulus: drop `rst_n_i` mid-cycle during RWAIT.
  - Required: outputs go to 0 immediately, no data beat follows, next transaction works.
